// File: rtl/input_map_pkg.sv
// ----------------------------------------------------------------------------
// input_map_pkg
// Shared constants for the memory-mapped input peripheral: register offsets
// within the input region and the access-size encoding used by the memory
// controller, the output map and this block.
// ----------------------------------------------------------------------------
package input_map_pkg;

    // Register offsets (byte address bits [3:0])
    localparam logic [3:0] SW_STATE_OFS  = 4'h0;
    localparam logic [3:0] BTN_STATE_OFS = 4'h4;
    localparam logic [3:0] BTN_EVENT_OFS = 4'h8;
    localparam logic [3:0] SW_CHANGE_OFS = 4'hC;

    // Access size encoding; 2'd3 is treated as a word access
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Data-lane mask for a given access size
    function automatic logic [31:0] size_mask(input logic [1:0] size);
        logic [31:0] m;
        case (size)
            SIZE_BYTE: m = 32'h0000_00FF;
            SIZE_HALF: m = 32'h0000_FFFF;
            default:   m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/input_map_debounce.sv
// ----------------------------------------------------------------------------
// debounce
// One-bit synchroniser and debouncer. The raw input passes through a two-flop
// synchroniser; the stable level only follows it after DEBOUNCE_CYCLES
// consecutive mismatching edges. Any edge where the synchronised value equals
// the stable level restarts the count.
//
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   i_raw    in  raw input, asynchronous to clk
//   o_stable out debounced level (registered)
//   o_change out high for the cycle ending on the edge where o_stable updates
// ----------------------------------------------------------------------------
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_change
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_mismatch;
    logic          w_change;

    assign w_mismatch = r_sync2 ^ r_stable;
    // Pulse is decoded from registered state so that downstream latches set
    // on the very edge where r_stable takes the new value.
    assign w_change   = w_mismatch && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_change) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_change = w_change;

endmodule

// File: rtl/input_map.sv
// ----------------------------------------------------------------------------
// input_map
// Memory-mapped input peripheral. Debounces the board switches and buttons and
// exposes four registers: debounced switch state (0x0), debounced button state
// (0x4), sticky button-press events (0x8, W1C) and sticky switch-change flags
// (0xC, W1C).
//
// Ports:
//   clk                 in   system clock
//   rst                 in   asynchronous active-high reset
//   sw                  in   raw switches (NUM_SW), asynchronous
//   btn                 in   raw buttons (NUM_BTN), asynchronous
//   input_address       in   byte address, bits [3:0] decoded
//   input_in            in   write data
//   input_size          in   0 byte, 1 half, 2/3 word
//   input_write_enable  in   write strobe, sampled on posedge clk
//   input_out           out  combinational read data
// ----------------------------------------------------------------------------
module input_map
    import input_map_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned NUM_SW          = 16,
    parameter int unsigned NUM_BTN         = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [31:0]        input_address,
    input  logic [31:0]        input_in,
    input  logic [1:0]         input_size,
    input  logic               input_write_enable,
    output logic [31:0]        input_out
);

    logic [NUM_SW-1:0]  w_sw_stable;
    logic [NUM_SW-1:0]  w_sw_change;
    logic [NUM_BTN-1:0] w_btn_stable;
    logic [NUM_BTN-1:0] w_btn_change;
    logic [NUM_BTN-1:0] w_btn_rise;

    logic [NUM_SW-1:0]  r_sw_change;
    logic [NUM_BTN-1:0] r_btn_event;

    logic [31:0]        w_wdata;
    logic [NUM_SW-1:0]  w_clr_sw;
    logic [NUM_BTN-1:0] w_clr_btn;
    logic [31:0]        w_rdata;
    logic               w_unused;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (sw[g]),
            .o_stable (w_sw_stable[g]),
            .o_change (w_sw_change[g])
        );
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (btn[g]),
            .o_stable (w_btn_stable[g]),
            .o_change (w_btn_change[g])
        );
    end

    // A change while the current stable level is 0 is a 0->1 press
    assign w_btn_rise = w_btn_change & ~w_btn_stable;

    // Write decode: full [3:0] compare so misaligned offsets never match
    assign w_wdata   = input_in & size_mask(input_size);
    assign w_clr_btn = (input_write_enable && input_address[3:0] == BTN_EVENT_OFS)
                       ? w_wdata[NUM_BTN-1:0] : '0;
    assign w_clr_sw  = (input_write_enable && input_address[3:0] == SW_CHANGE_OFS)
                       ? w_wdata[NUM_SW-1:0] : '0;

    // Set after clear: a simultaneous set and clear leaves the bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_event <= '0;
            r_sw_change <= '0;
        end else begin
            r_btn_event <= (r_btn_event & ~w_clr_btn) | w_btn_rise;
            r_sw_change <= (r_sw_change & ~w_clr_sw) | w_sw_change;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (input_address[3:0])
            SW_STATE_OFS:  w_rdata = 32'(w_sw_stable);
            BTN_STATE_OFS: w_rdata = 32'(w_btn_stable);
            BTN_EVENT_OFS: w_rdata = 32'(r_btn_event);
            SW_CHANGE_OFS: w_rdata = 32'(r_sw_change);
            default:       w_rdata = '0;
        endcase
    end

    assign input_out = w_rdata & size_mask(input_size);

    assign w_unused = ^{input_address[31:4], w_wdata};

endmodule
